// File: rtl/exec_issue_arbiter_pkg.sv
// ============================================================================
// Module : exec_issue_arbiter_pkg
// Brief  : Shared definitions for the dual-slot execution-unit issue arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exec_issue_arbiter_pkg;

  localparam int TAGW_DEFAULT = 4;

  // ctrl bundle layout: {ALUop[2:0], ExtOp, ALUSrc, RegDst}
  localparam int CTRL_W         = 6;
  localparam int CTRL_ALUOP_HI  = 5;
  localparam int CTRL_ALUOP_LO  = 3;
  localparam int CTRL_EXTOP     = 2;
  localparam int CTRL_ALUSRC    = 1;
  localparam int CTRL_REGDST    = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_e;

  // Pointer value after reset: "slot 1 won last", so slot 0 goes first.
  localparam logic ARB_LAST_RESET = 1'b1;

endpackage

`default_nettype wire

// File: rtl/exec_issue_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter owning the last-winner pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import exec_issue_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      // Pointer only moves on a real grant.
      if (|req) begin
        last_d = gnt[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= ARB_LAST_RESET;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_issue_arbiter.sv
// ============================================================================
// Module : exec_issue_arbiter
// Brief  : Shares one execution unit between two issue slots; issue and
//          result stages with valid/ready toward writeback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_issue_arbiter
  import exec_issue_arbiter_pkg::*;
#(
  parameter int TAGW = TAGW_DEFAULT,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_pc,
  input  logic [31:0]     req0_instr,
  input  logic [31:0]     req0_busA,
  input  logic [31:0]     req0_busB,
  input  logic [5:0]      req0_ctrl,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_pc,
  input  logic [31:0]     req1_instr,
  input  logic [31:0]     req1_busA,
  input  logic [31:0]     req1_busB,
  input  logic [5:0]      req1_ctrl,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     ex_pc,
  output logic [31:0]     ex_instr,
  output logic [31:0]     ex_busA,
  output logic [31:0]     ex_busB,
  output logic [2:0]      ex_ALUop,
  output logic            ex_ExtOp,
  output logic            ex_ALUSrc,
  output logic            ex_RegDst,
  input  logic [31:0]     ex_ALUout,
  input  logic [31:0]     ex_Target,
  input  logic            ex_zero,
  input  logic [4:0]      ex_Regout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_slot,
  output logic [TAGW-1:0] res_tag,
  output logic [31:0]     res_ALUout,
  output logic [31:0]     res_Target,
  output logic            res_zero,
  output logic [4:0]      res_Regout,
  output logic [CNTW-1:0] stall_cnt
);

  logic            i_valid_q, i_valid_d;
  logic            i_slot_q,  i_slot_d;
  logic [TAGW-1:0] i_tag_q,   i_tag_d;
  logic [31:0]     i_pc_q,    i_pc_d;
  logic [31:0]     i_instr_q, i_instr_d;
  logic [31:0]     i_busA_q,  i_busA_d;
  logic [31:0]     i_busB_q,  i_busB_d;
  logic [5:0]      i_ctrl_q,  i_ctrl_d;

  logic            r_valid_q, r_valid_d;
  logic            r_slot_q,  r_slot_d;
  logic [TAGW-1:0] r_tag_q,   r_tag_d;
  logic [31:0]     r_alu_q,   r_alu_d;
  logic [31:0]     r_tgt_q,   r_tgt_d;
  logic            r_zero_q,  r_zero_d;
  logic [4:0]      r_reg_q,   r_reg_d;

  logic [CNTW-1:0] stall_q,   stall_d;

  logic       w_r_free;
  logic       w_i_adv;
  logic       w_i_accept;
  logic       w_arb_en;
  logic [1:0] w_gnt;
  logic       w_grant;

  assign w_r_free   = !r_valid_q || res_ready;
  assign w_i_adv    = i_valid_q && w_r_free;
  assign w_i_accept = !i_valid_q || w_i_adv;
  assign w_arb_en   = w_i_accept && !flush && !reset;
  assign w_grant    = |w_gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .en    (w_arb_en),
    .gnt   (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  always_comb begin
    i_valid_d = i_valid_q;
    i_slot_d  = i_slot_q;
    i_tag_d   = i_tag_q;
    i_pc_d    = i_pc_q;
    i_instr_d = i_instr_q;
    i_busA_d  = i_busA_q;
    i_busB_d  = i_busB_q;
    i_ctrl_d  = i_ctrl_q;
    r_valid_d = r_valid_q;
    r_slot_d  = r_slot_q;
    r_tag_d   = r_tag_q;
    r_alu_d   = r_alu_q;
    r_tgt_d   = r_tgt_q;
    r_zero_d  = r_zero_q;
    r_reg_d   = r_reg_q;
    stall_d   = stall_q;

    if (flush) begin
      i_valid_d = 1'b0;
      r_valid_d = 1'b0;
    end else begin
      if (w_i_adv) begin
        r_valid_d = 1'b1;
        r_slot_d  = i_slot_q;
        r_tag_d   = i_tag_q;
        r_alu_d   = ex_ALUout;
        r_tgt_d   = ex_Target;
        r_zero_d  = ex_zero;
        r_reg_d   = ex_Regout;
      end else if (res_ready) begin
        r_valid_d = 1'b0;
      end

      if (w_grant) begin
        i_valid_d = 1'b1;
        i_slot_d  = w_gnt[1];
        i_tag_d   = w_gnt[1] ? req1_tag   : req0_tag;
        i_pc_d    = w_gnt[1] ? req1_pc    : req0_pc;
        i_instr_d = w_gnt[1] ? req1_instr : req0_instr;
        i_busA_d  = w_gnt[1] ? req1_busA  : req0_busA;
        i_busB_d  = w_gnt[1] ? req1_busB  : req0_busB;
        i_ctrl_d  = w_gnt[1] ? req1_ctrl  : req0_ctrl;
      end else if (w_i_adv) begin
        i_valid_d = 1'b0;
      end
    end

    // Backpressure counter is independent of flush; only reset clears it.
    if (r_valid_q && !res_ready && i_valid_q && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid_q <= 1'b0;
      i_slot_q  <= 1'b0;
      i_tag_q   <= '0;
      i_pc_q    <= '0;
      i_instr_q <= '0;
      i_busA_q  <= '0;
      i_busB_q  <= '0;
      i_ctrl_q  <= '0;
      r_valid_q <= 1'b0;
      r_slot_q  <= 1'b0;
      r_tag_q   <= '0;
      r_alu_q   <= '0;
      r_tgt_q   <= '0;
      r_zero_q  <= 1'b0;
      r_reg_q   <= '0;
      stall_q   <= '0;
    end else begin
      i_valid_q <= i_valid_d;
      i_slot_q  <= i_slot_d;
      i_tag_q   <= i_tag_d;
      i_pc_q    <= i_pc_d;
      i_instr_q <= i_instr_d;
      i_busA_q  <= i_busA_d;
      i_busB_q  <= i_busB_d;
      i_ctrl_q  <= i_ctrl_d;
      r_valid_q <= r_valid_d;
      r_slot_q  <= r_slot_d;
      r_tag_q   <= r_tag_d;
      r_alu_q   <= r_alu_d;
      r_tgt_q   <= r_tgt_d;
      r_zero_q  <= r_zero_d;
      r_reg_q   <= r_reg_d;
      stall_q   <= stall_d;
    end
  end

  assign ex_pc      = i_pc_q;
  assign ex_instr   = i_instr_q;
  assign ex_busA    = i_busA_q;
  assign ex_busB    = i_busB_q;
  assign ex_ALUop   = i_ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign ex_ExtOp   = i_ctrl_q[CTRL_EXTOP];
  assign ex_ALUSrc  = i_ctrl_q[CTRL_ALUSRC];
  assign ex_RegDst  = i_ctrl_q[CTRL_REGDST];

  assign res_valid  = r_valid_q;
  assign res_slot   = r_slot_q;
  assign res_tag    = r_tag_q;
  assign res_ALUout = r_alu_q;
  assign res_Target = r_tgt_q;
  assign res_zero   = r_zero_q;
  assign res_Regout = r_reg_q;
  assign stall_cnt  = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_issue_arbiter.sv
// ============================================================================
// Module : tb_exec_issue_arbiter
// Brief  : Directed-vector scoreboard bench for exec_issue_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_issue_arbiter;

  localparam int TAGW = 4;
  localparam int CNTW = 4;

  logic            clk;
  logic            reset, flush;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]     req0_pc, req0_instr, req0_busA, req0_busB;
  logic [31:0]     req1_pc, req1_instr, req1_busA, req1_busB;
  logic [5:0]      req0_ctrl, req1_ctrl;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic [31:0]     ex_pc, ex_instr, ex_busA, ex_busB;
  logic [2:0]      ex_ALUop;
  logic            ex_ExtOp, ex_ALUSrc, ex_RegDst;
  logic [31:0]     ex_ALUout, ex_Target;
  logic            ex_zero;
  logic [4:0]      ex_Regout;
  logic            res_valid, res_ready, res_slot, res_zero;
  logic [TAGW-1:0] res_tag;
  logic [31:0]     res_ALUout, res_Target;
  logic [4:0]      res_Regout;
  logic [CNTW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic            slot;
    logic [TAGW-1:0] tag;
    logic [31:0]     alu;
    logic [31:0]     tgt;
    logic            zero;
    logic [4:0]      rg;
  } exp_t;

  exp_t sb[$];

  exec_issue_arbiter #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
    .req0_instr(req0_instr), .req0_busA(req0_busA), .req0_busB(req0_busB),
    .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
    .req1_instr(req1_instr), .req1_busA(req1_busA), .req1_busB(req1_busB),
    .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_ALUop(ex_ALUop), .ex_ExtOp(ex_ExtOp), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegDst(ex_RegDst), .ex_ALUout(ex_ALUout), .ex_Target(ex_Target),
    .ex_zero(ex_zero), .ex_Regout(ex_Regout),
    .res_valid(res_valid), .res_ready(res_ready), .res_slot(res_slot),
    .res_tag(res_tag), .res_ALUout(res_ALUout), .res_Target(res_Target),
    .res_zero(res_zero), .res_Regout(res_Regout), .stall_cnt(stall_cnt)
  );

  // Stub execution unit: adder ALU, branch target, destination mux.
  assign ex_ALUout = ex_busA + ex_busB;
  assign ex_zero   = (ex_ALUout == 32'd0);
  assign ex_Target = ex_pc + {{14{ex_instr[15]}}, ex_instr[15:0], 2'b00};
  assign ex_Regout = ex_RegDst ? ex_instr[15:11] : ex_instr[20:16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t exp_for(input int n);
    exp_t        e;
    logic [31:0] a, b, pc, ins;
    logic [5:0]  c;
    a   = (n == 1) ? req1_busA  : req0_busA;
    b   = (n == 1) ? req1_busB  : req0_busB;
    pc  = (n == 1) ? req1_pc    : req0_pc;
    ins = (n == 1) ? req1_instr : req0_instr;
    c   = (n == 1) ? req1_ctrl  : req0_ctrl;
    e.slot = (n == 1);
    e.tag  = (n == 1) ? req1_tag : req0_tag;
    e.alu  = a + b;
    e.zero = ((a + b) == 32'd0);
    e.tgt  = pc + {{14{ins[15]}}, ins[15:0], 2'b00};
    e.rg   = c[0] ? ins[15:11] : ins[20:16];
    return e;
  endfunction

  task automatic load(input int n, input logic [3:0] tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ins, input logic [5:0] c);
    if (n == 1) begin
      req1_tag = tag; req1_busA = a; req1_busB = b; req1_instr = ins; req1_ctrl = c;
      req1_pc  = 32'h0000_1100 + {26'd0, tag, 2'b00};
    end else begin
      req0_tag = tag; req0_busA = a; req0_busB = b; req0_instr = ins; req0_ctrl = c;
      req0_pc  = 32'h0000_1000 + {26'd0, tag, 2'b00};
    end
  endtask

  // Apply one cycle of inputs, check the expected grants, push expected results.
  task automatic step(input logic v0, input logic v1, input logic fl, input logic rr,
                      input logic rs, input logic e0, input logic e1, input string nm);
    req0_valid = v0; req1_valid = v1; flush = fl; res_ready = rr; reset = rs;
    @(negedge clk);
    chk({nm, ".req0_ready"}, 32'(req0_ready), 32'(e0));
    chk({nm, ".req1_ready"}, 32'(req1_ready), 32'(e1));
    if (e0) sb.push_back(exp_for(0));
    if (e1) sb.push_back(exp_for(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".res_valid"},  32'(res_valid),  32'd0);
    chk({nm, ".stall_cnt"},  32'(stall_cnt),  32'd0);
    chk({nm, ".ex_pc"},      ex_pc,           32'd0);
    chk({nm, ".ex_instr"},   ex_instr,        32'd0);
    chk({nm, ".ex_busA"},    ex_busA,         32'd0);
    chk({nm, ".ex_ALUop"},   32'(ex_ALUop),   32'd0);
    chk({nm, ".res_ALUout"}, res_ALUout,      32'd0);
    chk({nm, ".res_Target"}, res_Target,      32'd0);
    chk({nm, ".res_Regout"}, 32'(res_Regout), 32'd0);
    chk({nm, ".res_slot"},   32'(res_slot),   32'd0);
    chk({nm, ".res_tag"},    32'(res_tag),    32'd0);
  endtask

  // Scoreboard monitor: every writeback handshake must match the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb.unexpected: got tag %h slot %0d expected no result", res_tag, res_slot);
        end else begin
          e = sb.pop_front();
          chk("sb.slot",   32'(res_slot),   32'(e.slot));
          chk("sb.tag",    32'(res_tag),    32'(e.tag));
          chk("sb.alu",    res_ALUout,      e.alu);
          chk("sb.target", res_Target,      e.tgt);
          chk("sb.zero",   32'(res_zero),   32'(e.zero));
          chk("sb.regout", 32'(res_Regout), 32'(e.rg));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; flush = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    load(0, 4'd0, 32'd0, 32'd0, 32'd0, 6'd0);
    load(1, 4'd0, 32'd0, 32'd0, 32'd0, 6'd0);
    @(posedge clk);
    #1;

    // Reset: no grants even with both slots requesting.
    step(1, 1, 0, 0, 1, 0, 0, "rst0");
    step(1, 1, 0, 0, 1, 0, 0, "rst1");
    chk_reset_vals("rst");

    // Single add from slot 0: 5 + 7.
    load(0, 4'd3, 32'd5, 32'd7, 32'h0085_1020, 6'h05);
    step(1, 0, 0, 1, 0, 1, 0, "t1.grant");
    chk("t1.ex_busA",  ex_busA,         32'd5);
    chk("t1.ex_busB",  ex_busB,         32'd7);
    chk("t1.ex_instr", ex_instr,        32'h0085_1020);
    chk("t1.ex_RegDst", 32'(ex_RegDst), 32'd1);
    chk("t1.res_valid0", 32'(res_valid), 32'd0);
    step(0, 0, 0, 1, 0, 0, 0, "t1.idle");
    chk("t1.res_valid1", 32'(res_valid), 32'd1);
    chk("t1.res_ALUout", res_ALUout,     32'd12);
    chk("t1.res_slot",   32'(res_slot),  32'd0);
    step(0, 0, 0, 1, 0, 0, 0, "t1.drain");
    chk("t1.res_valid2", 32'(res_valid), 32'd0);

    // Both slots contending with writeback always ready; slot 0 won last.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2; n++) begin
        load(n, 4'(4 + 4 * n + k),
             (k == 2 && n == 1) ? 32'hFFFF_FF00 : 32'(16 * k + n), 32'h100,
             {6'h08, 5'd3, 1'b0, 4'(4 + 4 * n + k), 5'd9, 11'(3 * k)},
             {3'(k), 1'b0, 1'b1, 1'b0});
      end
      step(1, 1, 0, 1, 0, (k % 2) == 1, (k % 2) == 0, $sformatf("t2.rr%0d", k));
      if (k == 1) begin
        chk("t2.ex_ALUop",  32'(ex_ALUop),  32'd1);
        chk("t2.ex_ALUSrc", 32'(ex_ALUSrc), 32'd1);
      end
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0, "t2.drain");
    chk("t2.sb_empty", 32'(sb.size()), 32'd0);

    // Fill both stages, hold writeback off for five cycles.
    load(0, 4'd1, 32'd100, 32'd1, 32'h0000_0010, 6'h01);
    step(1, 0, 0, 0, 0, 1, 0, "t3.fill0");
    load(1, 4'd2, 32'd200, 32'd2, 32'h0000_0020, 6'h01);
    step(0, 1, 0, 0, 0, 0, 1, "t3.fill1");
    load(0, 4'd5, 32'd300, 32'd3, 32'h0000_0030, 6'h01);
    load(1, 4'd6, 32'd400, 32'd4, 32'h0000_0040, 6'h01);
    for (int j = 0; j < 5; j++) begin
      step(1, 1, 0, 0, 0, 0, 0, "t3.stall");
      chk("t3.hold_valid", 32'(res_valid), 32'd1);
      chk("t3.hold_alu",   res_ALUout,     32'd101);
    end
    chk("t3.stall_cnt", 32'(stall_cnt), 32'd5);
    step(1, 1, 0, 1, 0, 1, 0, "t3.resume0");
    chk("t3.nobubble_valid", 32'(res_valid), 32'd1);
    chk("t3.nobubble_tag",   32'(res_tag),   32'd2);
    load(0, 4'd7, 32'd500, 32'd5, 32'h0000_0050, 6'h01);
    step(1, 1, 0, 1, 0, 0, 1, "t3.resume1");
    chk("t3.next_tag", 32'(res_tag), 32'd5);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0, "t3.drain");
    chk("t3.stall_kept", 32'(stall_cnt), 32'd5);
    chk("t3.sb_empty",   32'(sb.size()), 32'd0);

    // Long stall drives the 4-bit counter into saturation.
    load(0, 4'd8, 32'd10, 32'd20, 32'h0000_0100, 6'h00);
    step(1, 0, 0, 0, 0, 1, 0, "t4.fill0");
    load(1, 4'd9, 32'd30, 32'd40, 32'h0000_0200, 6'h00);
    step(0, 1, 0, 0, 0, 0, 1, "t4.fill1");
    for (int j = 1; j <= 12; j++) begin
      step(1, 1, 0, 0, 0, 0, 0, "t4.stall");
      chk($sformatf("t4.stall_cnt%0d", j), 32'(stall_cnt), (5 + j > 15) ? 32'd15 : 32'(5 + j));
    end

    // Flush with both stages full and both slots requesting; the result
    // already in R still completes its writeback in the flush cycle.
    load(0, 4'd10, 32'd1, 32'd1, 32'h0000_0300, 6'h00);
    load(1, 4'd11, 32'd2, 32'd2, 32'h0000_0400, 6'h00);
    step(1, 1, 1, 1, 0, 0, 0, "t5.flush");
    chk("t5.res_valid", 32'(res_valid), 32'd0);
    chk("t5.dropped",   32'(sb.size()), 32'd1);
    sb.delete();
    step(1, 1, 0, 1, 0, 1, 0, "t5.resume0");
    load(0, 4'd12, 32'd3, 32'd3, 32'h0000_0500, 6'h00);
    step(1, 1, 0, 1, 0, 0, 1, "t5.resume1");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0, "t5.drain");
    chk("t5.sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream after slot 0 won last: reset returns priority to slot 0.
    load(1, 4'd13, 32'd7, 32'd7, 32'h0000_0600, 6'h00);
    step(0, 1, 0, 0, 0, 0, 1, "t6.fill1");
    load(0, 4'd14, 32'd8, 32'd8, 32'h0000_0700, 6'h00);
    step(1, 0, 0, 0, 0, 1, 0, "t6.fill0");
    step(1, 1, 0, 0, 1, 0, 0, "t6.reset");
    chk_reset_vals("t6");
    sb.delete();
    step(1, 1, 0, 1, 0, 1, 0, "t6.contest");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0, "t6.drain");
    chk("t6.sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
